// File: rtl/tx_prio_doorbell_sched.sv
// tx_prio_doorbell_sched: strict-priority doorbell scheduler issuing tagged TX requests bounded by an op table
module tx_prio_doorbell_sched #(
  parameter int QUEUE_INDEX_WIDTH = 6,
  parameter int PRIO_LEVELS       = 4,
  parameter int PRIORITY_WIDTH    = 6,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TABLE_SIZE     = 16,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_doorbell_queue,
  input  logic [PRIORITY_WIDTH-1:0]            s_axis_doorbell_priority,
  input  logic                                 s_axis_doorbell_valid,
  output logic                                 s_axis_doorbell_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_tx_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]             m_axis_tx_req_tag,
  output logic                                 m_axis_tx_req_valid,
  input  logic                                 m_axis_tx_req_ready,
  input  logic [LEN_WIDTH-1:0]                 s_axis_tx_req_status_len,
  input  logic [REQ_TAG_WIDTH-1:0]             s_axis_tx_req_status_tag,
  input  logic                                 s_axis_tx_req_status_valid,
  output logic                                 active,
  output logic [$clog2(OP_TABLE_SIZE+1)-1:0]   outstanding,
  output logic                                 status_err
);
  localparam int QIW = QUEUE_INDEX_WIDTH;
  localparam int NQ  = 2**QIW;
  localparam int PW  = PRIO_LEVELS > 1 ? $clog2(PRIO_LEVELS) : 1;
  localparam int SW  = OP_TABLE_SIZE > 1 ? $clog2(OP_TABLE_SIZE) : 1;
  localparam int OW  = $clog2(OP_TABLE_SIZE+1);
  logic [QIW-1:0]           fifo_q [PRIO_LEVELS][NQ];
  logic [QIW:0]             wr_q [PRIO_LEVELS];
  logic [QIW:0]             rd_q [PRIO_LEVELS];
  logic [PW-1:0]            prio_q [NQ];
  logic [NQ-1:0]            enq_q, infl_q, db_q;
  logic [OP_TABLE_SIZE-1:0] used_q;
  logic [QIW-1:0]           slot_queue_q [OP_TABLE_SIZE];
  logic                     valid_q, status_err_q;
  logic [QIW-1:0]           req_queue_q;
  logic [REQ_TAG_WIDTH-1:0] req_tag_q;
  logic [OW-1:0]            outstanding_q;
  logic                     db_acc, st_hit, st_push, db_push, push, issue, free_found;
  logic [PW-1:0]            db_prio, push_lvl, pop_lvl;
  logic [SW-1:0]            st_slot, free_slot;
  logic [QIW-1:0]           dq, st_q, push_q, pop_q;
  logic [PRIO_LEVELS-1:0]   ne;
  assign s_axis_doorbell_ready = !s_axis_tx_req_status_valid;
  assign m_axis_tx_req_valid   = valid_q;
  assign m_axis_tx_req_queue   = req_queue_q;
  assign m_axis_tx_req_tag     = req_tag_q;
  assign outstanding           = outstanding_q;
  assign status_err            = status_err_q;
  assign active                = |ne || |used_q;
  // Pick this cycle's single enqueue source, the level to pop and the lowest free op slot
  always_comb begin
    dq       = s_axis_doorbell_queue;
    db_acc   = s_axis_doorbell_valid && !s_axis_tx_req_status_valid;
    db_prio  = int'(s_axis_doorbell_priority) >= PRIO_LEVELS-1 ? PW'(PRIO_LEVELS-1) : s_axis_doorbell_priority[PW-1:0];
    st_slot  = s_axis_tx_req_status_tag[SW-1:0];
    st_hit   = s_axis_tx_req_status_valid && int'(s_axis_tx_req_status_tag) < OP_TABLE_SIZE && used_q[st_slot];
    st_q     = slot_queue_q[st_slot];
    st_push  = st_hit && (s_axis_tx_req_status_len != '0 || db_q[st_q]);
    db_push  = db_acc && !enq_q[dq] && !infl_q[dq];
    push     = st_push || db_push;
    push_q   = st_push ? st_q : dq;
    push_lvl = st_push ? prio_q[st_q] : db_prio;
    ne       = '0;
    pop_lvl  = '0;
    for (int l = 0; l < PRIO_LEVELS; l++) begin
      ne[l] = wr_q[l] != rd_q[l];
      if (ne[l]) pop_lvl = PW'(l);
    end
    free_found = 1'b0;
    free_slot  = '0;
    for (int s = OP_TABLE_SIZE-1; s >= 0; s--) begin
      if (!used_q[s]) begin
        free_found = 1'b1;
        free_slot  = SW'(s);
      end
    end
    pop_q = fifo_q[pop_lvl][rd_q[pop_lvl][QIW-1:0]];
    issue = enable && free_found && (!valid_q || m_axis_tx_req_ready) && |ne;
  end
  // Storage without reset: FIFO entries and per-slot queue owner are only read when marked valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[push_lvl][wr_q[push_lvl][QIW-1:0]] <= push_q;
    if (issue) slot_queue_q[free_slot] <= pop_q;
  end
  // Per-queue flags, FIFO pointers, op table occupancy and the registered request
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q          <= '{default: '0};
      rd_q          <= '{default: '0};
      prio_q        <= '{default: '0};
      enq_q         <= '0;
      infl_q        <= '0;
      db_q          <= '0;
      used_q        <= '0;
      valid_q       <= 1'b0;
      req_queue_q   <= '0;
      req_tag_q     <= '0;
      outstanding_q <= '0;
      status_err_q  <= 1'b0;
    end else begin
      if (db_acc) begin
        prio_q[dq] <= db_prio;
        if (infl_q[dq]) db_q[dq] <= 1'b1;
      end
      if (st_hit) begin
        used_q[st_slot] <= 1'b0;
        infl_q[st_q]    <= 1'b0;
        db_q[st_q]      <= 1'b0;
      end
      if (s_axis_tx_req_status_valid && !st_hit) status_err_q <= 1'b1;
      if (push) begin
        enq_q[push_q]  <= 1'b1;
        wr_q[push_lvl] <= wr_q[push_lvl] + 1'b1;
      end
      if (issue) begin
        rd_q[pop_lvl]     <= rd_q[pop_lvl] + 1'b1;
        enq_q[pop_q]      <= 1'b0;
        infl_q[pop_q]     <= 1'b1;
        used_q[free_slot] <= 1'b1;
        valid_q           <= 1'b1;
        req_queue_q       <= pop_q;
        req_tag_q         <= REQ_TAG_WIDTH'(free_slot);
      end else if (m_axis_tx_req_ready) begin
        valid_q <= 1'b0;
      end
      outstanding_q <= outstanding_q + OW'(issue) - OW'(st_hit);
    end
  end
endmodule

// File: tb/tb_tx_prio_doorbell_sched.sv
// tb_tx_prio_doorbell_sched: random and directed stimulus checked against a queue-based reference model
module tb_tx_prio_doorbell_sched;
  localparam int NQ  = 64;
  localparam int PL  = 4;
  localparam int OTS = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [5:0]  db_q = '0;
  logic [5:0]  db_p = '0;
  logic        db_v = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] st_len = '0;
  logic [7:0]  st_tag = '0;
  logic        st_v = 1'b0;
  logic        db_ready, req_valid, active, status_err;
  logic [5:0]  req_queue;
  logic [7:0]  req_tag;
  logic [4:0]  outstanding;
  int n_tests = 0;
  int n_fail  = 0;
  int mq [PL][$];
  bit menq [NQ];
  bit minfl [NQ];
  bit mdb [NQ];
  int mprio [NQ];
  bit mused [OTS];
  int mslotq [OTS];
  bit mvalid, merr;
  int mreq_q, mreq_tag, mout;
  tx_prio_doorbell_sched dut (
    .clk(clk), .rst(rst), .enable(en),
    .s_axis_doorbell_queue(db_q), .s_axis_doorbell_priority(db_p),
    .s_axis_doorbell_valid(db_v), .s_axis_doorbell_ready(db_ready),
    .m_axis_tx_req_queue(req_queue), .m_axis_tx_req_tag(req_tag),
    .m_axis_tx_req_valid(req_valid), .m_axis_tx_req_ready(rdy),
    .s_axis_tx_req_status_len(st_len), .s_axis_tx_req_status_tag(st_tag),
    .s_axis_tx_req_status_valid(st_v),
    .active(active), .outstanding(outstanding), .status_err(status_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    foreach (mq[l]) mq[l].delete();
    for (int q = 0; q < NQ; q++) begin
      menq[q] = 0; minfl[q] = 0; mdb[q] = 0; mprio[q] = 0;
    end
    for (int s = 0; s < OTS; s++) mused[s] = 0;
    mvalid = 0; merr = 0; mreq_q = 0; mreq_tag = 0; mout = 0;
  endtask
  task automatic model_step();
    int lvl = -1;
    int slot = -1;
    int q, sq;
    bit hit, do_issue;
    for (int l = 0; l < PL; l++) if (mq[l].size() > 0) lvl = l;
    for (int s = OTS-1; s >= 0; s--) if (!mused[s]) slot = s;
    do_issue = en && slot >= 0 && lvl >= 0 && (!mvalid || rdy);
    hit = st_v && int'(st_tag) < OTS && mused[st_tag];
    if (st_v && !hit) merr = 1;
    if (hit) begin
      sq = mslotq[st_tag];
      mused[st_tag] = 0;
      minfl[sq] = 0;
      mout--;
      if (st_len != 0 || mdb[sq]) begin
        mq[mprio[sq]].push_back(sq);
        menq[sq] = 1;
        mdb[sq] = 0;
      end
    end else if (db_v && !st_v) begin
      q = int'(db_q);
      mprio[q] = int'(db_p) > PL-1 ? PL-1 : int'(db_p);
      if (menq[q]) begin
      end else if (minfl[q]) mdb[q] = 1;
      else begin
        mq[mprio[q]].push_back(q);
        menq[q] = 1;
      end
    end
    if (do_issue) begin
      q = mq[lvl].pop_front();
      menq[q] = 0;
      minfl[q] = 1;
      mused[slot] = 1;
      mslotq[slot] = q;
      mvalid = 1;
      mreq_q = q;
      mreq_tag = slot;
      mout++;
    end else if (rdy) mvalid = 0;
  endtask
  function automatic bit model_active();
    for (int l = 0; l < PL; l++) if (mq[l].size() > 0) return 1;
    for (int s = 0; s < OTS; s++) if (mused[s]) return 1;
    return 0;
  endfunction
  task automatic step();
    #1 chk("db_ready", db_ready, !st_v);
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    chk("req_valid", req_valid, mvalid);
    if (mvalid) begin
      chk("req_queue", req_queue, mreq_q);
      chk("req_tag", req_tag, mreq_tag);
    end
    chk("outstanding", outstanding, mout);
    chk("active", active, model_active());
    chk("status_err", status_err, merr);
  endtask
  task automatic idle();
    db_v = 0; st_v = 0; rst = 0;
  endtask
  task automatic rand_inputs(input int qmax, input int st_pct, input int rdy_pct);
    int used_list[$];
    rst  = $urandom_range(0, 999) < 2;
    en   = $urandom_range(0, 99) < 90;
    rdy  = $urandom_range(0, 99) < rdy_pct;
    db_v = $urandom_range(0, 1);
    db_q = 6'($urandom_range(0, qmax));
    db_p = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
    st_v = $urandom_range(0, 99) < st_pct;
    for (int s = 0; s < OTS; s++) if (mused[s]) used_list.push_back(s);
    if (used_list.size() > 0 && $urandom_range(0, 9) != 0)
      st_tag = 8'(used_list[$urandom_range(0, used_list.size()-1)]);
    else
      st_tag = 8'($urandom_range(0, 31));
    st_len = $urandom_range(0, 1) ? 16'($urandom_range(1, 1500)) : 16'd0;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    step();
    step();
    chk("rst_valid", req_valid, 0);
    chk("rst_active", active, 0);
    rst = 0; en = 1; rdy = 1;
    db_v = 1; db_q = 6'd5; db_p = 6'd2;
    step();
    idle();
    step();
    chk("lat_valid", req_valid, 1);
    chk("lat_queue", req_queue, 5);
    chk("lat_tag", req_tag, 0);
    st_v = 1; st_tag = 8'd0; st_len = 16'd64;
    step();
    idle();
    step();
    chk("requeue_valid", req_valid, 1);
    chk("requeue_queue", req_queue, 5);
    chk("requeue_tag", req_tag, 0);
    st_v = 1; st_tag = 8'd0; st_len = 16'd0;
    step();
    idle();
    step();
    chk("idle_active", active, 0);
    st_v = 1; st_tag = 8'd30;
    step();
    idle();
    chk("err_set", status_err, 1);
    chk("err_outstanding", outstanding, 0);
    rst = 1;
    step();
    rst = 0;
    chk("rst_err", status_err, 0);
    chk("rst_out", outstanding, 0);
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(19, 4, 80);
      step();
    end
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(63, 35, 60);
      step();
    end
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(7, 20, 40);
      step();
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
